bids_nway: RTL and testbench

BIDS_NWAY -- requirements
Module: bids_nway

---
 rtl/bids_nway_if.sv | 37 +++
 rtl/bids_nway.sv | 243 ++++++++++++++++++++++++
 tb/tb_bids_nway.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bids_nway_if.sv
// bids_nway_if -- bidder/control/result signal bundle for bids_nway.
//
// Parameters: NBID (bidders), AMT_W (bid amount width), BAL_W (balance width).
// master: drives bid, bidAmt, retract, C_start, C_op, C_data;
//         observes ack, bidErr, win, balance, maxBid, ready, roundOver, err.
// slave : the auction block (bids_nway), opposite directions.
interface bids_nway_if #(
  parameter int NBID  = 3,
  parameter int AMT_W = 16,
  parameter int BAL_W = 32
) ();
  logic [NBID-1:0]       bid;
  logic [NBID*AMT_W-1:0] bidAmt;
  logic [NBID-1:0]       retract;
  logic                  C_start;
  logic [3:0]            C_op;
  logic [31:0]           C_data;

  logic [NBID-1:0]       ack;
  logic [2*NBID-1:0]     bidErr;
  logic [NBID-1:0]       win;
  logic [NBID*BAL_W-1:0] balance;
  logic [AMT_W-1:0]      maxBid;
  logic                  ready;
  logic                  roundOver;
  logic [2:0]            err;

  modport master (
    output bid, bidAmt, retract, C_start, C_op, C_data,
    input  ack, bidErr, win, balance, maxBid, ready, roundOver, err
  );

  modport slave (
    input  bid, bidAmt, retract, C_start, C_op, C_data,
    output ack, bidErr, win, balance, maxBid, ready, roundOver, err
  );
endinterface

// File: rtl/bids_nway.sv
// bids_nway -- N-bidder sealed auction controller with key lock.
//
// Ports: clk (only clock), reset_n (async active-low), bus (bids_nway_if.slave):
//   bid/bidAmt/retract per-bidder strobes and amounts, C_start round level,
//   C_op/C_data control opcode and operand; ack/bidErr per-bidder pulses,
//   win/maxBid held result, balance current balances, ready/roundOver/err.
// Build option: define BIDS_LOCKOUT_EN to enable the bad-key LOCKOUT timer.
//
// state    | meaning
// UNLOCKED | configuration ops accepted
// LOCKED   | keyed; waiting for round start or unlock
// ROUND    | bids collected while C_start stays high
// RESULT   | one cycle after the round closed, winner already posted
// LOCKOUT  | bad key penalty, counting down the timer
module bids_nway #(
  parameter int NBID  = 3,
  parameter int AMT_W = 16,
  parameter int BAL_W = 32
) (
  input logic       clk,
  input logic       reset_n,
  bids_nway_if.slave bus
);

  typedef enum logic [2:0] {
    S_UNLOCKED, S_LOCKED, S_ROUND, S_RESULT, S_LOCKOUT
  } state_e;

  localparam logic [3:0] NBID_L  = 4'(NBID);
  localparam logic [2:0] E_NONE  = 3'b000;
  localparam logic [2:0] E_KEY   = 3'b001;
  localparam logic [2:0] E_UNLK  = 3'b010;
  localparam logic [2:0] E_START = 3'b011;
  localparam logic [2:0] E_OP    = 3'b100;
  localparam logic [2:0] E_TIE   = 3'b101;
  localparam logic [1:0] B_INACT = 2'b01;
  localparam logic [1:0] B_FUNDS = 2'b10;
  localparam logic [1:0] B_MASK  = 2'b11;

  state_e                     state_q;
  logic [NBID-1:0][BAL_W-1:0] bal_q;
  logic [NBID-1:0][AMT_W-1:0] held_q;
  logic [NBID-1:0][1:0]       bid_err_q;
  logic [NBID-1:0]            mask_q;
  logic [NBID-1:0]            ack_q;
  logic [NBID-1:0]            win_q;
  logic [AMT_W-1:0]           max_bid_q;
  logic [BAL_W-1:0]           cost_q;
  logic [31:0]                key_q;
  logic [2:0]                 idx_q;
  logic                       ready_q;
  logic                       round_over_q;
  logic [2:0]                 err_q;
`ifdef BIDS_LOCKOUT_EN
  logic [31:0]                timer_q;
  logic [31:0]                lock_cnt_q;
`endif

  // Highest nonzero held bid and how many bidders share it.
  logic [AMT_W-1:0] res_max;
  logic [3:0]       res_cnt;
  logic [2:0]       res_idx;

  always_comb begin
    res_max = '0;
    res_cnt = '0;
    res_idx = '0;
    for (int i = 0; i < NBID; i++) begin
      if (held_q[i] > res_max) begin
        res_max = held_q[i];
        res_cnt = 4'd1;
        res_idx = 3'(i);
      end else if (held_q[i] == res_max && held_q[i] != '0) begin
        res_cnt = res_cnt + 4'd1;
      end
    end
  end

  // Funds check widened by one bit so amount+cost cannot wrap.
  logic [NBID-1:0] short_funds;
  logic [BAL_W:0]  need;

  always_comb begin
    short_funds = '0;
    need        = '0;
    for (int i = 0; i < NBID; i++) begin
      need = (BAL_W+1)'(bus.bidAmt[i*AMT_W +: AMT_W]) + (BAL_W+1)'(cost_q);
      short_funds[i] = {1'b0, bal_q[i]} < need;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_UNLOCKED;
      bal_q        <= '0;
      held_q       <= '0;
      bid_err_q    <= '0;
      mask_q       <= '1;
      ack_q        <= '0;
      win_q        <= '0;
      max_bid_q    <= '0;
      cost_q       <= BAL_W'(1);
      key_q        <= '0;
      idx_q        <= '0;
      ready_q      <= 1'b0;
      round_over_q <= 1'b0;
      err_q        <= E_NONE;
`ifdef BIDS_LOCKOUT_EN
      timer_q      <= 32'hF;
      lock_cnt_q   <= '0;
`endif
    end else begin
      ack_q        <= '0;
      bid_err_q    <= '0;
      err_q        <= E_NONE;
      round_over_q <= 1'b0;
      ready_q      <= 1'b1;

      // The round only accepts bids while C_start is still high; the closing
      // cycle counts as inactive.
      for (int i = 0; i < NBID; i++) begin
        if ((bus.bid[i] || bus.retract[i]) && !(state_q == S_ROUND && bus.C_start))
          bid_err_q[i] <= B_INACT;
      end

      case (state_q)
        S_UNLOCKED: begin
          if (bus.C_start) begin
            err_q <= E_START;
          end else begin
            case (bus.C_op)
              4'd0: begin end
              4'd1: err_q <= E_UNLK;
              4'd2: begin
                key_q   <= bus.C_data;
                state_q <= S_LOCKED;
              end
              4'd3: begin
                if ({1'b0, bus.C_data[2:0]} < NBID_L) idx_q <= bus.C_data[2:0];
                else                                  err_q <= E_OP;
              end
              4'd4: begin
                for (int i = 0; i < NBID; i++)
                  if (idx_q == 3'(i)) bal_q[i] <= BAL_W'(bus.C_data);
              end
              4'd5: mask_q <= bus.C_data[NBID-1:0];
`ifdef BIDS_LOCKOUT_EN
              4'd6: timer_q <= bus.C_data;
`else
              4'd6: err_q <= E_OP;
`endif
              4'd7: cost_q <= BAL_W'(bus.C_data);
              default: err_q <= E_OP;
            endcase
          end
        end

        S_LOCKED: begin
          if (bus.C_start) begin
            state_q   <= S_ROUND;
            held_q    <= '0;
            win_q     <= '0;
            max_bid_q <= '0;
          end else if (bus.C_op == 4'd1) begin
            if (bus.C_data == key_q) begin
              state_q <= S_UNLOCKED;
            end else begin
              err_q <= E_KEY;
`ifdef BIDS_LOCKOUT_EN
              lock_cnt_q <= timer_q;
              state_q    <= S_LOCKOUT;
              ready_q    <= 1'b0;
`endif
            end
          end else if (bus.C_op != 4'd0) begin
            err_q <= E_OP;
          end
        end

        S_ROUND: begin
          if (!bus.C_start) begin
            state_q      <= S_RESULT;
            round_over_q <= 1'b1;
            if (res_cnt > 4'd1) begin
              err_q <= E_TIE;
            end else if (res_cnt == 4'd1) begin
              max_bid_q <= res_max;
              for (int i = 0; i < NBID; i++) begin
                if (res_idx == 3'(i)) begin
                  win_q[i] <= 1'b1;
                  bal_q[i] <= bal_q[i] - BAL_W'(res_max);
                end
              end
            end
          end else begin
            for (int i = 0; i < NBID; i++) begin
              if (bus.bid[i]) begin
                if (!mask_q[i]) begin
                  bid_err_q[i] <= B_MASK;
                end else if (short_funds[i]) begin
                  bid_err_q[i] <= B_FUNDS;
                  bal_q[i]     <= (bal_q[i] > cost_q) ? bal_q[i] - cost_q : '0;
                end else begin
                  ack_q[i]  <= 1'b1;
                  bal_q[i]  <= bal_q[i] - cost_q;
                  held_q[i] <= bus.bidAmt[i*AMT_W +: AMT_W];
                end
              end else if (bus.retract[i]) begin
                held_q[i] <= '0;
              end
            end
          end
        end

        S_RESULT: state_q <= S_LOCKED;

`ifdef BIDS_LOCKOUT_EN
        S_LOCKOUT: begin
          // Terminal count at 1 so a timer of N keeps ready low for N cycles.
          if (lock_cnt_q <= 32'd1) begin
            state_q <= S_LOCKED;
          end else begin
            lock_cnt_q <= lock_cnt_q - 32'd1;
            ready_q    <= 1'b0;
          end
        end
`endif

        default: state_q <= S_UNLOCKED;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.bidErr    = bid_err_q;
  assign bus.win       = win_q;
  assign bus.balance   = bal_q;
  assign bus.maxBid    = max_bid_q;
  assign bus.ready     = ready_q;
  assign bus.roundOver = round_over_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bids_nway.sv
module tb_bids_nway;
  localparam int NBID  = 3;
  localparam int AMT_W = 16;
  localparam int BAL_W = 32;
`ifdef BIDS_LOCKOUT_EN
  localparam bit LK_EN = 1'b1;
`else
  localparam bit LK_EN = 1'b0;
`endif

  localparam int M_UNL = 0, M_LCK = 1, M_RND = 2, M_RES = 3, M_LKO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bids_nway_if #(.NBID(NBID), .AMT_W(AMT_W), .BAL_W(BAL_W)) ifc ();

  bids_nway #(.NBID(NBID), .AMT_W(AMT_W), .BAL_W(BAL_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_mode;
  longint          m_bal  [NBID];
  longint          m_held [NBID];
  bit [NBID-1:0]   m_mask;
  longint          m_timer, m_cost, m_left;
  bit [31:0]       m_key;
  int              m_idx;
  bit [NBID-1:0]   e_ack, e_win;
  bit [2*NBID-1:0] e_berr;
  longint          e_max;
  bit              e_ready, e_ro;
  bit [2:0]        e_err;

  task automatic model_reset();
    m_mode = M_UNL;
    for (int i = 0; i < NBID; i++) begin m_bal[i] = 0; m_held[i] = 0; end
    m_mask = '1; m_timer = 15; m_cost = 1; m_key = 0; m_idx = 0; m_left = 0;
    e_ack = 0; e_win = 0; e_berr = 0; e_max = 0; e_ready = 0; e_ro = 0; e_err = 0;
  endtask

  task automatic model_unlocked_op(input int op, input bit [31:0] d);
    case (op)
      0: ;
      1: e_err = 3'b010;
      2: begin m_key = d; m_mode = M_LCK; end
      3: if (int'(d[2:0]) < NBID) m_idx = int'(d[2:0]); else e_err = 3'b100;
      4: m_bal[m_idx] = longint'(d);
      5: m_mask = d[NBID-1:0];
      6: if (LK_EN) m_timer = longint'(d); else e_err = 3'b100;
      7: m_cost = longint'(d);
      default: e_err = 3'b100;
    endcase
  endtask

  task automatic model_step();
    bit     live;
    longint amt, top;
    int     winners[$];
    e_ack = 0; e_berr = 0; e_ro = 0; e_err = 0;
    live = (m_mode == M_RND) && ifc.C_start;
    for (int i = 0; i < NBID; i++)
      if (!live && (ifc.bid[i] || ifc.retract[i])) e_berr[2*i +: 2] = 2'b01;
    case (m_mode)
      M_UNL: if (ifc.C_start) e_err = 3'b011;
             else model_unlocked_op(int'(ifc.C_op), ifc.C_data);
      M_LCK: begin
        if (ifc.C_start) begin
          m_mode = M_RND; e_win = 0; e_max = 0;
          for (int i = 0; i < NBID; i++) m_held[i] = 0;
        end else if (ifc.C_op == 4'd1) begin
          if (ifc.C_data == m_key) m_mode = M_UNL;
          else begin
            e_err = 3'b001;
            if (LK_EN) begin m_mode = M_LKO; m_left = m_timer; end
          end
        end else if (ifc.C_op != 4'd0) e_err = 3'b100;
      end
      M_RND: begin
        if (!ifc.C_start) begin
          top = 0;
          for (int i = 0; i < NBID; i++) if (m_held[i] > top) top = m_held[i];
          for (int i = 0; i < NBID; i++) if (top > 0 && m_held[i] == top) winners.push_back(i);
          if (winners.size() > 1) e_err = 3'b101;
          else if (winners.size() == 1) begin
            e_win[winners[0]] = 1'b1;
            e_max = top;
            m_bal[winners[0]] -= top;
          end
          e_ro = 1; m_mode = M_RES;
        end else begin
          for (int i = 0; i < NBID; i++) begin
            amt = longint'(ifc.bidAmt[i*AMT_W +: AMT_W]);
            if (ifc.bid[i]) begin
              if (!m_mask[i]) e_berr[2*i +: 2] = 2'b11;
              else if (m_bal[i] < amt + m_cost) begin
                e_berr[2*i +: 2] = 2'b10;
                m_bal[i] = (m_bal[i] > m_cost) ? m_bal[i] - m_cost : 0;
              end else begin
                e_ack[i] = 1'b1;
                m_bal[i] -= m_cost;
                m_held[i] = amt;
              end
            end else if (ifc.retract[i]) m_held[i] = 0;
          end
        end
      end
      M_RES: m_mode = M_LCK;
      default: begin
        m_left--;
        if (m_left <= 0) m_mode = M_LCK;
      end
    endcase
    e_ready = (m_mode != M_LKO);
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", 64'(ifc.ack), 64'(e_ack));
      check("bidErr", 64'(ifc.bidErr), 64'(e_berr));
      check("win", 64'(ifc.win), 64'(e_win));
      check("maxBid", 64'(ifc.maxBid), 64'(e_max));
      check("ready", 64'(ifc.ready), 64'(e_ready));
      check("roundOver", 64'(ifc.roundOver), 64'(e_ro));
      check("err", 64'(ifc.err), 64'(e_err));
      for (int i = 0; i < NBID; i++)
        check($sformatf("balance%0d", i), 64'(ifc.balance[i*BAL_W +: BAL_W]),
              64'(m_bal[i][BAL_W-1:0]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] o, input logic [31:0] d);
    ifc.C_op = o; ifc.C_data = d;
    step();
    ifc.C_op = '0; ifc.C_data = '0;
  endtask

  task automatic load_bal(input int i, input int v);
    op(4'd3, 32'(i));
    op(4'd4, 32'(v));
  endtask

  task automatic set_bids(input logic [NBID-1:0] b, input int a0, input int a1, input int a2);
    ifc.bid = b;
    ifc.bidAmt[0*AMT_W +: AMT_W] = AMT_W'(a0);
    ifc.bidAmt[1*AMT_W +: AMT_W] = AMT_W'(a1);
    ifc.bidAmt[2*AMT_W +: AMT_W] = AMT_W'(a2);
  endtask

  function automatic logic [63:0] bal_of(input int i);
    return 64'(ifc.balance[i*BAL_W +: BAL_W]);
  endfunction

  initial begin
    bit cs;
    int o;
    logic [31:0] d;
    ifc.bid = '0; ifc.bidAmt = '0; ifc.retract = '0;
    ifc.C_start = 1'b0; ifc.C_op = '0; ifc.C_data = '0;
    repeat (3) step();
    chk_en = 1'b1;
    check("rst_ready", 64'(ifc.ready), 64'd0);
    check("rst_bal0", bal_of(0), 64'd0);
    reset_n = 1'b1;
    step();
    check("ready_up", 64'(ifc.ready), 64'd1);

    // Winner round: 10/30/20 on balances of 100
    load_bal(0, 100); load_bal(1, 100); load_bal(2, 100);
    op(4'd2, 32'd5);
    ifc.C_start = 1'b1; step();
    set_bids(3'b111, 10, 30, 20); step();
    check("win_ack", 64'(ifc.ack), 64'h7);
    set_bids(3'b000, 0, 0, 0);
    ifc.C_start = 1'b0; step();
    check("win_ro", 64'(ifc.roundOver), 64'd1);
    check("win_win", 64'(ifc.win), 64'h2);
    check("win_max", 64'(ifc.maxBid), 64'd30);
    check("win_bal0", bal_of(0), 64'd99);
    check("win_bal1", bal_of(1), 64'd69);
    check("win_bal2", bal_of(2), 64'd99);
    step();
    check("win_hold", 64'(ifc.win), 64'h2);
    check("ro_pulse", 64'(ifc.roundOver), 64'd0);

    // Masked bidder
    op(4'd1, 32'd5);
    op(4'd5, 32'h5);
    op(4'd2, 32'd5);
    ifc.C_start = 1'b1; step();
    set_bids(3'b010, 0, 5, 0); step();
    check("mask_berr", 64'(ifc.bidErr), 64'h0C);
    check("mask_ack", 64'(ifc.ack), 64'd0);
    check("mask_bal1", bal_of(1), 64'd69);
    set_bids(3'b000, 0, 0, 0);
    ifc.C_start = 1'b0; step();
    check("mask_win", 64'(ifc.win), 64'd0);
    step();

    // Insufficient funds: balance 10, cost 1, bid 10
    op(4'd1, 32'd5);
    op(4'd5, 32'h7);
    load_bal(0, 10);
    op(4'd2, 32'd5);
    ifc.C_start = 1'b1; step();
    set_bids(3'b001, 10, 0, 0); step();
    check("funds_berr", 64'(ifc.bidErr), 64'h02);
    check("funds_bal0", bal_of(0), 64'd9);
    set_bids(3'b000, 0, 0, 0);
    ifc.C_start = 1'b0; step(); step();

    // Tie at maximum
    op(4'd1, 32'd5);
    load_bal(0, 100); load_bal(1, 100); load_bal(2, 100);
    op(4'd2, 32'd5);
    ifc.C_start = 1'b1; step();
    set_bids(3'b111, 40, 40, 5); step();
    set_bids(3'b000, 0, 0, 0);
    ifc.C_start = 1'b0; step();
    check("tie_err", 64'(ifc.err), 64'h5);
    check("tie_win", 64'(ifc.win), 64'd0);
    check("tie_max", 64'(ifc.maxBid), 64'd0);
    check("tie_bal0", bal_of(0), 64'd99);
    check("tie_bal1", bal_of(1), 64'd99);
    step();

    // Bad key
    op(4'd1, 32'd5);
    op(4'd6, 32'd3);
    check("settimer_err", 64'(ifc.err), LK_EN ? 64'd0 : 64'h4);
    op(4'd2, 32'd5);
    op(4'd1, 32'd6);
    check("badkey_err", 64'(ifc.err), 64'h1);
    if (LK_EN) begin
      check("lock_rdy0", 64'(ifc.ready), 64'd0);
      step(); check("lock_rdy1", 64'(ifc.ready), 64'd0);
      step(); check("lock_rdy2", 64'(ifc.ready), 64'd0);
      step(); check("lock_rdy3", 64'(ifc.ready), 64'd1);
    end else begin
      check("nolock_rdy", 64'(ifc.ready), 64'd1);
    end
    op(4'd1, 32'd5);
    check("goodkey_err", 64'(ifc.err), 64'd0);
    op(4'd1, 32'd0);
    check("unlocked_err", 64'(ifc.err), 64'h2);

    // Bid, retract, then reset mid-round
    op(4'd2, 32'd5);
    ifc.C_start = 1'b1; step();
    set_bids(3'b001, 50, 0, 0); step();
    check("ret_ack", 64'(ifc.ack), 64'h1);
    set_bids(3'b000, 0, 0, 0);
    ifc.retract = 3'b001; step();
    check("ret_berr", 64'(ifc.bidErr), 64'd0);
    ifc.retract = '0;
    reset_n = 1'b0;
    #1;
    check("rst_win", 64'(ifc.win), 64'd0);
    check("rst_max", 64'(ifc.maxBid), 64'd0);
    check("rst_balance", 64'(|ifc.balance), 64'd0);
    check("rst_rdy", 64'(ifc.ready), 64'd0);
    check("rst_ack", 64'(ifc.ack), 64'd0);
    ifc.C_start = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();

    // Randomized traffic against the model
    cs = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        reset_n = 1'b0; step(); step(); reset_n = 1'b1; cs = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) cs = ~cs;
      ifc.C_start = cs;
      for (int i = 0; i < NBID; i++) begin
        ifc.bid[i]     = ($urandom_range(0, 2) == 0);
        ifc.retract[i] = ($urandom_range(0, 3) == 0);
        ifc.bidAmt[i*AMT_W +: AMT_W] = AMT_W'($urandom_range(0, 120));
      end
      if ($urandom_range(0, 1) == 0) o = 0;
      else if ($urandom_range(0, 3) == 0) o = int'($urandom_range(8, 15));
      else o = int'($urandom_range(1, 7));
      case (o)
        1: d = ($urandom_range(0, 1) == 0) ? m_key : 32'($urandom_range(0, 9));
        2: d = 32'($urandom_range(0, 9));
        3: d = 32'($urandom_range(0, 7));
        4: d = 32'($urandom_range(0, 300));
        6: d = 32'($urandom_range(0, 5));
        7: d = 32'($urandom_range(0, 4));
        default: d = $urandom;
      endcase
      ifc.C_op = 4'(o);
      ifc.C_data = d;
      step();
    end
    ifc.C_op = '0; ifc.C_data = '0; ifc.bid = '0; ifc.retract = '0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
